// File: rtl/work_loader.sv
// Serial job intake: shifts 8 midstate words and 16 second-chunk words, then offers the job via valid/ready.
// Optional WORK_LOADER_BSWAP_EN byte-reverses each accepted word before shifting.
module work_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_found,
  input  logic [31:0]  word_in,
  input  logic         word_valid,
  input  logic         work_ready,
  output logic [255:0] midstate,
  output logic [511:0] block_data,
  output logic         work_valid,
  output logic [2:0]   controller_state,
  output logic         midstate_shifts_done,
  output logic         remaining_shifts_done,
  output logic         overflow_err
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MID_WORDS = 8;
  localparam int unsigned BLK_WORDS = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    MIDSTATE  = 3'b001,
    REMAINING = 3'b010,
    READY     = 3'b011
  } state_t;

  state_t            state;
  logic [3:0]        mid_cnt;
  logic [4:0]        blk_cnt;
  logic [WORD_W-1:0] w;

`ifdef WORK_LOADER_BSWAP_EN
  assign w = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
`else
  assign w = word_in;
`endif

  assign controller_state = state;

  // Job load controller; start_found overrides whatever the current state is doing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      mid_cnt               <= '0;
      blk_cnt               <= '0;
      midstate              <= '0;
      block_data            <= '0;
      work_valid            <= 1'b0;
      midstate_shifts_done  <= 1'b0;
      remaining_shifts_done <= 1'b0;
      overflow_err          <= 1'b0;
    end else begin
      overflow_err <= 1'b0;
      if (start_found) begin
        state                 <= MIDSTATE;
        blk_cnt               <= '0;
        work_valid            <= 1'b0;
        midstate_shifts_done  <= 1'b0;
        remaining_shifts_done <= 1'b0;
        mid_cnt               <= word_valid ? 4'd1 : 4'd0;
        if (word_valid) midstate <= {midstate[223:0], w};
      end else begin
        case (state)
          IDLE: begin
            if (word_valid) overflow_err <= 1'b1;
          end
          MIDSTATE: begin
            if (word_valid) begin
              midstate <= {midstate[223:0], w};
              mid_cnt  <= mid_cnt + 4'd1;
              if (mid_cnt == 4'(MID_WORDS - 1)) begin
                midstate_shifts_done <= 1'b1;
                state                <= REMAINING;
              end
            end
          end
          REMAINING: begin
            if (word_valid) begin
              block_data <= {block_data[479:0], w};
              blk_cnt    <= blk_cnt + 5'd1;
              if (blk_cnt == 5'(BLK_WORDS - 1)) begin
                remaining_shifts_done <= 1'b1;
                work_valid            <= 1'b1;
                state                 <= READY;
              end
            end
          end
          READY: begin
            // Data stays frozen; stray words are dropped and flagged.
            if (word_valid) overflow_err <= 1'b1;
            if (work_valid && work_ready) begin
              state                 <= IDLE;
              work_valid            <= 1'b0;
              midstate_shifts_done  <= 1'b0;
              remaining_shifts_done <= 1'b0;
              mid_cnt               <= '0;
              blk_cnt               <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_work_loader.sv
// Randomized scoreboard bench for work_loader: a job-level model predicts register contents,
// latencies and overflow pulses; a monitor checks each completed job as it appears.
module tb_work_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_found = 1'b0;
  logic [31:0]  word_in = '0;
  logic         word_valid = 1'b0;
  logic         work_ready = 1'b0;
  logic [255:0] midstate;
  logic [511:0] block_data;
  logic         work_valid;
  logic [2:0]   controller_state;
  logic         midstate_shifts_done;
  logic         remaining_shifts_done;
  logic         overflow_err;

  work_loader dut (
    .clk(clk), .rst(rst), .start_found(start_found), .word_in(word_in),
    .word_valid(word_valid), .work_ready(work_ready), .midstate(midstate),
    .block_data(block_data), .work_valid(work_valid), .controller_state(controller_state),
    .midstate_shifts_done(midstate_shifts_done), .remaining_shifts_done(remaining_shifts_done),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] mid;
    logic [511:0] blk;
    int           lat;
    int           mid_lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_pass = 0;
  int edge_cnt = 0, start_edge = 0;
  int exp_ovf = 0, ovf_seen = 0, jobs_exp = 0, jobs_seen = 0;
  logic prev_md = 1'b0, prev_wv = 1'b0;
  exp_t mon_e;
  exp_t ea, eb, etmp;
  logic [31:0] wa [24];
  logic [31:0] wr_words [24];

  always @(posedge clk) edge_cnt++;

  function automatic logic [31:0] model_word(input logic [31:0] x);
`ifdef WORK_LOADER_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic check_vec(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, "_midstate"}, 512'(midstate), 512'(0));
    check_vec({tag, "_block"}, block_data, 512'(0));
    check_int({tag, "_ctrl"}, int'({work_valid, controller_state, midstate_shifts_done,
                                    remaining_shifts_done, overflow_err}), 0);
  endtask

  task automatic drive(input logic sf, input logic wv, input logic wr, input logic [31:0] w);
    start_found = sf;
    word_valid  = wv;
    work_ready  = wr;
    word_in     = w;
    @(posedge clk);
    #1;
    start_found = 1'b0;
    word_valid  = 1'b0;
    work_ready  = 1'b0;
  endtask

  // Drives the first n words of a job; a full 24-word job is predicted and queued.
  task automatic run_job(input logic [31:0] w [24], input int gap_mode, input int n,
                         input bit wr0, output exp_t e);
    int g [24];
    int idx;
    idx = 0;
    e.lat = 0;
    e.mid_lat = 0;
    for (int k = 0; k < 24; k++) begin
      g[k] = (k == 0) ? 0 : ((gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode);
      if (k > 0) idx += g[k] + 1;
      if (k == 7) e.mid_lat = idx + 1;
      if (k == 23) e.lat = idx + 1;
    end
    for (int i = 0; i < 8; i++) e.mid[255 - 32*i -: 32] = model_word(w[i]);
    for (int i = 0; i < 16; i++) e.blk[511 - 32*i -: 32] = model_word(w[8 + i]);
    if (n == 24) begin
      sb.push_back(e);
      jobs_exp++;
    end
    for (int k = 0; k < n; k++) begin
      repeat (g[k]) drive(1'b0, 1'b0, 1'b0, $urandom);
      drive(k == 0, 1'b1, (k == 0) ? wr0 : 1'b0, w[k]);
      if (k == 0) start_edge = edge_cnt;
    end
  endtask

  task automatic handoff(input int noise);
    for (int i = 0; i < noise; i++) begin
      drive(1'b0, 1'b1, 1'b0, $urandom);
      exp_ovf++;
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    check_int("handoff_state", int'(controller_state), 0);
  endtask

  // Monitor: pops the scoreboard whenever a job becomes valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow_err) ovf_seen++;
      if (midstate_shifts_done && !prev_md && sb.size() > 0)
        check_int("mid_done_latency", edge_cnt - start_edge + 1, sb[0].mid_lat);
      if (work_valid && !prev_wv) begin
        if (sb.size() == 0) begin
          check_int("unexpected_job", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          jobs_seen++;
          check_vec("job_midstate", 512'(midstate), 512'(mon_e.mid));
          check_vec("job_block", block_data, mon_e.blk);
          check_int("job_latency", edge_cnt - start_edge + 1, mon_e.lat);
          check_int("job_state", int'(controller_state), 3);
          check_int("job_flags", int'({midstate_shifts_done, remaining_shifts_done}), 3);
        end
      end
    end
    prev_md = midstate_shifts_done;
    prev_wv = work_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed back-to-back job 1..24
    for (int k = 0; k < 24; k++) wa[k] = 32'(k + 1);
    run_job(wa, 0, 24, 1'b0, ea);
    check_vec("first_mid_word0", 512'(midstate[255:224]), 512'(model_word(32'h1)));
    check_vec("first_mid_word7", 512'(midstate[31:0]), 512'(model_word(32'h8)));
    check_vec("first_blk_word0", 512'(block_data[511:480]), 512'(model_word(32'h9)));
    check_vec("first_blk_word15", 512'(block_data[31:0]), 512'(model_word(32'h18)));

    // Hold READY while stray words arrive
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, $urandom);
      exp_ovf++;
      check_int("hold_ovf", int'(overflow_err), 1);
      check_int("hold_state", int'(controller_state), 3);
      check_vec("hold_data", {midstate, block_data[511:256]} ^ {ea.mid, ea.blk[511:256]},
                512'(0));
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    check_int("release_ctrl", int'({work_valid, controller_state, midstate_shifts_done,
                                    remaining_shifts_done}), 0);
    check_vec("release_keeps_mid", 512'(midstate), 512'(ea.mid));

    // Stray words in IDLE
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, $urandom);
      exp_ovf++;
    end

    // Restart after 5 midstate words
    for (int k = 0; k < 24; k++) wr_words[k] = $urandom;
    run_job(wr_words, 0, 5, 1'b0, etmp);
    for (int k = 0; k < 24; k++) wa[k] = $urandom;
    run_job(wa, 0, 24, 1'b0, eb);

    // Abandon from READY, then restart from READY together with work_ready
    for (int k = 0; k < 24; k++) wa[k] = $urandom;
    run_job(wa, -1, 24, 1'b0, etmp);
    for (int k = 0; k < 24; k++) wa[k] = $urandom;
    run_job(wa, 0, 24, 1'b1, etmp);
    handoff(1);

    // Gapped load of 1..24 matches the back-to-back contents
    for (int k = 0; k < 24; k++) wa[k] = 32'(k + 1);
    run_job(wa, 2, 24, 1'b0, etmp);
    check_vec("gapped_mid", 512'(midstate), 512'(ea.mid));
    check_vec("gapped_blk", block_data, ea.blk);
    handoff(0);

    // Asynchronous reset after 12 block words
    for (int k = 0; k < 24; k++) wa[k] = $urandom;
    run_job(wa, 0, 20, 1'b0, etmp);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 24; k++) wa[k] = $urandom;
    run_job(wa, 0, 24, 1'b0, etmp);
    handoff(2);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 24; k++) wa[k] = $urandom;
      if (j == 0) wa[0] = 32'h11223344;
      run_job(wa, -1, 24, 1'b0, etmp);
      if (j == 0) check_vec("word0_order", 512'(midstate[255:224]), 512'(model_word(32'h11223344)));
      handoff(int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(0, 2))) drive(1'b0, 1'b0, 1'b0, $urandom);
    end

    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    check_int("scoreboard_empty", sb.size(), 0);
    check_int("jobs_seen", jobs_seen, jobs_exp);
    check_int("overflow_pulses", ovf_seen, exp_ovf);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/work_loader.md
# work_loader

Serial work-intake stage for the miner core. It accepts a job as a stream of 32-bit words: 8 midstate words, then 16 second-chunk words. Words are shifted into a 256-bit midstate register and a 512-bit block register. The block then presents the completed job to the hashing core with a valid/ready handshake. It exposes the same phase flags and 3-bit controller-state encoding used by the shift-timing logic, so the two stay interchangeable on the controller bus.

## Interface
Parameters:
- none (word counts fixed: 8 midstate, 16 block words)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_found  input  1  single-cycle pulse marking the first word of a new job
- word_in  input  32  incoming job word
- word_valid  input  1  word_in valid this cycle
- work_ready  input  1  hashing core accepts the job this cycle
- midstate  output  256  shifted midstate; word 0 ends in [255:224]
- block_data  output  512  shifted second chunk; word 0 ends in [511:480]
- work_valid  output  1  complete job held on midstate/block_data
- controller_state  output  3  000 IDLE, 001 MIDSTATE, 010 REMAINING, 011 READY
- midstate_shifts_done  output  1  level; 8 midstate words captured for the current job
- remaining_shifts_done  output  1  level; 16 block words captured
- overflow_err  output  1  one-cycle pulse; word_valid arrived while not loading

## Operation
- Internal counters: mid_cnt is 4 bits, counting 0..8; blk_cnt is 5 bits, counting 0..16. Both clear on start_found and on job hand-off.
- IDLE: ignores words. If word_valid=1 without start_found, pulses overflow_err.
- start_found has priority in every state:
  - clears both counters and both done flags
  - drops work_valid and enters MIDSTATE
  - a word_valid in the same cycle is accepted as midstate word 0, and mid_cnt becomes 1
- MIDSTATE: each accepted word shifts as midstate <= {midstate[223:0], w}.
  - When the 8th word is accepted: midstate_shifts_done goes to 1 and the state moves to REMAINING.
- REMAINING: each accepted word shifts as block_data <= {block_data[479:0], w}.
  - When the 16th word is accepted: remaining_shifts_done goes to 1, work_valid goes to 1, and the state moves to READY.
- READY: midstate and block_data are frozen.
  - word_valid without start_found pulses overflow_err, and the word is dropped.
  - When work_valid and work_ready are both 1: next state is IDLE, work_valid and both done flags clear, and the data registers keep their contents.
- start_found in READY together with work_ready: the hand-off counts as accepted, and the new load begins (MIDSTATE).
- start_found in READY without work_ready: the job is abandoned and the new load begins.
- Unused encodings 1xx: recover to IDLE on the next clock.

## Timing
- Reset values: midstate=0, block_data=0, work_valid=0, controller_state=000, both done flags=0, overflow_err=0, counters=0.
- Reset mid-load returns to IDLE immediately and asynchronously; the partial job is discarded.
- Flags and state update on the clock edge that accepts the qualifying word; they are visible the next cycle.
- Minimum job latency: the start_found cycle, plus 23 more back-to-back words, then work_valid is high on the following cycle (24 cycles from start_found to work_valid).
- Gaps in word_valid are legal in MIDSTATE and REMAINING; counters hold.
- No combinational path from any input to any output.

## Configuration
- WORK_LOADER_BSWAP_EN
  - Defined: each accepted word is byte-reversed before shifting ({w[7:0],w[15:8],w[23:16],w[31:24]}). This converts little-endian pool data to SHA-256 word order.
  - Undefined: words are shifted unmodified.
  - Counters, flags and timing are identical in both builds.

## Test plan
- Reset then load: start_found with words 0x00000001..0x00000018 back-to-back.
  - midstate_shifts_done rises 8 cycles after start_found; work_valid rises 24 cycles after start_found.
  - midstate[255:224]=0x00000001, midstate[31:0]=0x00000008, block_data[511:480]=0x00000009, block_data[31:0]=0x00000018.
- Hold READY with work_ready=0 for 10 cycles while driving word_valid.
  - Data unchanged; overflow_err pulses once per word; state stays 011.
  - Assert work_ready: IDLE next cycle, and flags clear.
- Restart: start_found again after 5 midstate words.
  - Counters restart; new job completes normally; the old words are fully shifted out of midstate.
- Gapped input (word_valid every 3rd cycle) completes with identical register contents to the back-to-back case.
- Assert rst during REMAINING (after 12 block words).
  - All outputs are zero in the same cycle; a following clean job succeeds.
- With WORK_LOADER_BSWAP_EN defined: word_in=0x11223344 as word 0 gives midstate[255:224]=0x44332211.
